// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_hs
//  Purpose  : Parametrised valid/ready pipeline register stage. It has a
//             synchronous flush and an optional two-entry skid buffer.
//  Revision : 1.0  initial release
//
//  Configuration macro:
//    PIPE_SKID_EN  defined   -> two-entry stage (main + skid register).
//                               in_ready comes from a flop, and occ is 0..2.
//    PIPE_SKID_EN  undefined -> single register.
//                               in_ready = !out_valid || out_ready, and
//                               occ is 0..1.
//
//  Parameters:
//    WIDTH    data width in bits (>= 1)
//    RST_VAL  value loaded into the data registers on reset and on flush
//
//  Ports:
//    che        in   clock, rising edge
//    rst        in   asynchronous reset, active low
//    flush      in   synchronous clear of all held beats
//    in_valid   in   upstream beat present
//    in_ready   out  stage can accept a beat this cycle
//    in_data    in   upstream payload
//    out_valid  out  beat available downstream
//    out_ready  in   downstream accepts this cycle
//    out_data   out  payload of the oldest held beat
//    occ        out  number of beats held
// ============================================================================
module pipe_stage_hs #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             che,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  // The state encoding equals the occupancy, so occ is a direct copy of it.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             pop;
  logic             load_main_in;
  logic [WIDTH-1:0] main_q;
`ifdef PIPE_SKID_EN
  logic             load_main_skid;
  logic             load_skid;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
`endif

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and register-load decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    load_main_in = 1'b0;
`ifdef PIPE_SKID_EN
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
`endif
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          // Pass-through: the new beat replaces the one leaving.
          load_main_in = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (accept) begin
          // The downstream stalled while a beat was already in flight.
          // Park the beat in skid, so that main (and out_data) stay stable.
          state_nxt = ST_FULL;
          load_skid = 1'b1;
`endif
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      ST_FULL: begin
        // in_ready is low here, so only a pop can occur.
        if (pop) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
`else
      ST_FULL: state_nxt = ST_EMPTY;  // unreachable without skid
`endif
      default: state_nxt = ST_EMPTY;
    endcase

    // Flush wins over any accept or pop in the same cycle.
    if (flush) begin
      state_nxt = ST_EMPTY;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = (state != ST_EMPTY);
    out_data  = main_q;
`ifdef PIPE_SKID_EN
    in_ready  = in_ready_q;
    occ       = state;
`else
    in_ready  = !out_valid || out_ready;
    occ       = {1'b0, state[0]};
`endif
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      main_q <= RST_VAL;
    end else if (flush) begin
      main_q <= RST_VAL;
    end else if (load_main_in) begin
      main_q <= in_data;
`ifdef PIPE_SKID_EN
    end else if (load_main_skid) begin
      main_q <= skid_q;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      skid_q <= RST_VAL;
    end else if (flush) begin
      skid_q <= RST_VAL;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  // Registered ready: it is a copy of "next state is not FULL". This keeps
  // out_ready from reaching in_ready through combinational logic.
  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_hs
//  Purpose  : Self-checking bench for pipe_stage_hs. It has three parts:
//             a table of single-cycle vectors, hand-written multi-cycle
//             sequences, and a random phase checked against a queue model.
//             The bench follows PIPE_SKID_EN the same way the design does.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int          W    = 16;
  localparam logic [W-1:0] RV  = 16'hA5A5;
`ifdef PIPE_SKID_EN
  localparam bit          SKID = 1'b1;
`else
  localparam bit          SKID = 1'b0;
`endif

  logic         che;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occ;

  int checks;
  int errors;

  pipe_stage_hs #(.WIDTH(W), .RST_VAL(RV)) dut (
    .che       (che),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  initial che = 1'b0;
  always #5 che = ~che;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         ev;
    logic [W-1:0] ed;
    logic         cd;
    logic [1:0]   eocc;
    logic         eir;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic step();
    @(posedge che);
    #1;
  endtask

  task automatic expect_all(input string name, input logic ev, input logic [W-1:0] ed,
                            input logic cd, input logic [1:0] eocc, input logic eir);
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (cd) chk({name, ".data"}, {16'd0, out_data}, {16'd0, ed});
    chk({name, ".occ"}, {30'd0, occ}, {30'd0, eocc});
    chk({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, eir});
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge che);
    #1 rst = 1'b1;
  endtask

  // Reference model: a FIFO of held beats, holding at most CAP entries.
  logic [W-1:0] mq[$];

  function automatic logic model_ready(input logic r);
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // ---------------- vector table ----------------
    tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 2'd1, 1'b1};
    tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 2'd1, 1'b1};
    tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 2'd1, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1};
    tbl[4] = '{1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b1, 2'd1, SKID};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b1, 2'd1, SKID};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1};
    tbl[7] = '{1'b1, 16'h0009, 1'b0, 1'b1, 1'b0, RV,       1'b1, 2'd0, 1'b1};

    do_reset();
    expect_all("reset", 1'b0, RV, 1'b1, 2'd0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      step();
      expect_all($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].cd, tbl[i].eocc, tbl[i].eir);
    end

    // ---------------- streaming 0x1..0x10 ----------------
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      expect_all($sformatf("stream%0d", i), 1'b1, W'(i), 1'b1, 2'd1, 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    expect_all("stream_drain", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // ---------------- output hold ----------------
    drive(1'b1, 16'h0055, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_all($sformatf("hold%0d", i), 1'b1, 16'h0055, 1'b1, 2'd1, SKID);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

`ifdef PIPE_SKID_EN
    // ---------------- stall with skid ----------------
    drive(1'b1, 16'h000A, 1'b1, 1'b0);
    step();
    expect_all("stall_a", 1'b1, 16'h000A, 1'b1, 2'd1, 1'b1);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    step();
    expect_all("stall_full", 1'b1, 16'h000A, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 16'h000C, 1'b0, 1'b0);
    step();
    expect_all("stall_held", 1'b1, 16'h000A, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 16'h000C, 1'b1, 1'b0);
    step();
    expect_all("stall_b", 1'b1, 16'h000B, 1'b1, 2'd1, 1'b1);
    step();
    expect_all("stall_c", 1'b1, 16'h000C, 1'b1, 2'd1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    expect_all("stall_empty", 1'b0, '0, 1'b0, 2'd0, 1'b1);
`else
    // ---------------- combinational ready ----------------
    drive(1'b1, 16'h0044, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h0066, 1'b0, 1'b0);
    #1 chk("nsk_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 chk("nsk_ready_high", {31'd0, in_ready}, 32'd1);
    step();
    expect_all("nsk_replace", 1'b1, 16'h0066, 1'b1, 2'd1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
`endif

    // ---------------- flush collision ----------------
    drive(1'b1, 16'h0031, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0032, 1'b0, 1'b0);
    step();
    chk("flush_pre_occ", {30'd0, occ}, SKID ? 32'd2 : 32'd1);
    drive(1'b1, 16'h0077, 1'b1, 1'b1);
    step();
    expect_all("flush", 1'b0, RV, 1'b1, 2'd0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all($sformatf("flush_after%0d", i), 1'b0, RV, 1'b1, 2'd0, 1'b1);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    step();
    chk("rst_pre_occ", {30'd0, occ}, SKID ? 32'd2 : 32'd1);
    #2 rst = 1'b0;
    #1 expect_all("async_rst", 1'b0, RV, 1'b1, 2'd0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    expect_all("post_rst", 1'b0, RV, 1'b1, 2'd0, 1'b1);

    // ---------------- random vs queue model ----------------
    do_reset();
    mq.delete();
    for (int n = 0; n < 2000; n++) begin
      logic v, r, f, acc, pp, flushed;
      logic [W-1:0] d;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 31) == 0);
      d = W'($urandom);
      drive(v, d, r, f);
      acc = v && model_ready(r);
      pp  = (mq.size() > 0) && r;
      step();
      flushed = f;
      if (f) begin
        mq.delete();
      end else begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
      if (mq.size() > 0) begin
        expect_all($sformatf("rnd%0d", n), 1'b1, mq[0], 1'b1, 2'(mq.size()), model_ready(r));
      end else begin
        expect_all($sformatf("rnd%0d", n), 1'b0, RV, flushed, 2'd0, model_ready(r));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
